axi_burst_master: RTL
=====================

// Module: axi_burst_master
// PURPOSE
//  AXI4 master that turns single burst commands into AW/W/B or AR/R transactions. Pairs with the
//  axi_ram slave in test_gpgpu_axi_top benches and in loaders that preload or dump memory. Handles one
//  transaction at a time. Write beats come in on a valid/ready stream; read beats go out on another.
// PARAMETERS
//  DATA_WIDTH  64               AXI data width in bits; power of two, >= 8
//  ADDR_WIDTH  32               AXI address width
//  STRB_WIDTH  DATA_WIDTH/8     wstrb width
//  ID_WIDTH    4                AXI ID width
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous, active-high reset
//  cmd_valid    in   1           command request
//  cmd_ready    out  1           command accepted when cmd_valid && cmd_ready
//  cmd_write    in   1           1 = write burst, 0 = read burst
//  cmd_addr     in   ADDR_WIDTH  start byte address; aligned to STRB_WIDTH
//  cmd_len      in   8           beats minus 1 (AXI len encoding)
//  cmd_id       in   ID_WIDTH    AXI ID driven on awid/arid
//  wr_data/wr_strb in DATA/STRB  write beat payload
//  wr_valid/wr_ready  in/out 1   write beat handshake
//  rd_data      out  DATA_WIDTH  read beat payload (= m_axi_rdata)
//  rd_last      out  1           final read beat (= m_axi_rlast)
//  rd_valid/rd_ready  out/in 1   read beat handshake
//  done         out  1           1-cycle pulse when a transaction completes
//  m_axi_aw*    out  id,addr,len,size,burst,lock,cache,prot,valid; m_axi_awready in
//  m_axi_w*     out  data,strb,last,valid; m_axi_wready in
//  m_axi_b*     in   id,resp,valid; m_axi_bready out
//  m_axi_ar*    out  id,addr,len,size,burst,lock,cache,prot,valid; m_axi_arready in
//  m_axi_r*     in   id,data,resp,last,valid; m_axi_rready out
// BEHAVIOUR
//  - FSM states: IDLE, AW, W, B, AR, R. cmd_ready = (state==IDLE), driven combinationally.
//  - IDLE: on cmd handshake, latch addr/len/id. Go to AW if cmd_write, else AR. Beat counter loads cmd_len.
//  - AW/AR: the valid is registered and held with stable payload until ready. Then go to W or R.
//  - Fixed outputs: size=$clog2(STRB_WIDTH), burst=2'b01 (INCR), lock=0, cache=4'b0011, prot=0.
//  - W: m_axi_wvalid=wr_valid, wr_ready=m_axi_wready, data/strb pass through, all combinational.
//    m_axi_wlast=(count==0). Each handshake decrements count. Last beat -> B.
//  - B: m_axi_bready=1. On bvalid go to IDLE and pulse done the next cycle (registered).
//  - R: m_axi_rready=rd_ready, rd_valid=m_axi_rvalid, pass-through with zero latency.
//    An rvalid&&rready with rlast -> IDLE and pulse done. rlast is taken from the slave, not the counter.
//  - Outside W, wr_ready=0 and wvalid=0. Outside R, rd_valid=0 and rready=0. Outside B, bready=0.
//  - cmd_len=0: single beat; wlast is asserted on the first W beat.
//  - cmd_len=255: 256 beats; the counter is 8 bit and never wraps before wlast.
//  - No 4 KB boundary split; the command issuer keeps bursts within 4 KB.
//  - cmd_valid while busy: held off by cmd_ready=0, no queueing.
//  - done and the next cmd handshake can fall in the same cycle, since IDLE is re-entered before done.
//  - Reset values: state=IDLE, all AXI valids/readies=0, done=0, cmd_ready=0 while rst is high.
//  - Reset mid-burst: abandon immediately, deassert all valids. The slave must be reset together with it.
// CONFIGURATION
//  AXI_MASTER_ERR_CHECK_EN defined:
//    - Adds outputs err (sticky, 1 bit) and err_code (2 bit: last non-OKAY resp).
//    - err is set when bresp!=0, rresp!=0, bid/rid!=latched id, or rlast arrives before count==0.
//    - err clears only on rst.
//  AXI_MASTER_ERR_CHECK_EN undefined:
//    - No err ports. resp and ID fields are ignored. R ends purely on rlast.
// TESTING (DUT connected to axi_ram, DATA_WIDTH=64)
//  1. Write addr=0x100, len=3, data 0x11..0x44, strb=0xFF.
//     -> 4 W beats, wlast on beat 4, one done pulse. mem[0x20..0x23] holds the data.
//  2. Read addr=0x100, len=3, rd_ready=1.
//     -> rd_data 0x11,0x22,0x33,0x44, rd_last on beat 4, done once.
//  3. Write len=0, strb=0x0F, data=0xAABBCCDD_EEFF0011 over 0.
//     -> wlast on the first beat. A read-back returns 0x00000000_EEFF0011.
//  4. Read len=7 with rd_ready toggling 1,0,1,0.
//     -> 8 beats, no beat lost or repeated, rready always equals rd_ready.
//  5. Issue the next command while busy, then assert rst in the middle of W beat 2.
//     -> cmd_ready=0 while busy. After reset: IDLE, all valids=0, cmd_ready=1 one cycle after rst falls.
//  6. ERR_CHECK_EN, slave forced to bresp=2'b10.
//     -> err=1, err_code=2'b10. err still set after a following clean transfer.

Source files
------------

// File: rtl/axi_burst_master.sv
// axi_burst_master: one-transaction-at-a-time AXI4 burst master (AW/W/B or AR/R).
// Define AXI_MASTER_ERR_CHECK_EN to add sticky err/err_code response checking.
module axi_burst_master #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
`ifdef AXI_MASTER_ERR_CHECK_EN
  output logic                  err,
  output logic [1:0]            err_code,
`endif
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  awvalid_q, awvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  done_q, done_d;

  wire w_hs = wr_valid & m_axi_wready;
  wire r_hs = m_axi_rvalid & rd_ready;

  // Address channels carry the latched command until the slave accepts it.
  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = wr_strb;
  assign rd_data     = m_axi_rdata;
  assign rd_last     = m_axi_rlast;
  assign done        = done_q;

  // Next-state and handshake steering for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    awvalid_d    = awvalid_q;
    arvalid_d    = arvalid_q;
    done_d       = 1'b0;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    m_axi_wvalid = 1'b0;
    m_axi_wlast  = 1'b0;
    m_axi_bready = 1'b0;
    m_axi_rready = 1'b0;
    rd_valid     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          id_d   = cmd_id;
          cnt_d  = cmd_len;
          if (cmd_write) begin
            state_d   = S_AW;
            awvalid_d = 1'b1;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_AW: begin
        if (m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = S_W;
        end
      end
      S_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = (cnt_q == 8'd0);
        if (w_hs) begin
          if (cnt_q == 8'd0) begin
            state_d = S_B;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_R;
        end
      end
      S_R: begin
        m_axi_rready = rd_ready;
        rd_valid     = m_axi_rvalid;
        if (r_hs) begin
          cnt_d = cnt_q - 8'd1;
          if (m_axi_rlast) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and command registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      awvalid_q <= awvalid_d;
      arvalid_q <= arvalid_d;
      done_q    <= done_d;
    end
  end

`ifdef AXI_MASTER_ERR_CHECK_EN
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;

  assign err      = err_q;
  assign err_code = code_q;

  // Sticky error on bad response, ID mismatch or early rlast.
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (state_q == S_B && m_axi_bvalid) begin
      if (m_axi_bresp != 2'b00) begin
        err_d  = 1'b1;
        code_d = m_axi_bresp;
      end
      if (m_axi_bid != id_q) err_d = 1'b1;
    end
    if (state_q == S_R && r_hs) begin
      if (m_axi_rresp != 2'b00) begin
        err_d  = 1'b1;
        code_d = m_axi_rresp;
      end
      if (m_axi_rid != id_q) err_d = 1'b1;
      if (m_axi_rlast && cnt_q != 8'd0) err_d = 1'b1;
    end
  end

  // Error state survives everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      code_q <= 2'b00;
    end else begin
      err_q  <= err_d;
      code_q <= code_d;
    end
  end
`else
  logic unused;
  assign unused = ^{m_axi_bid, m_axi_bresp, m_axi_rid, m_axi_rresp};
`endif

endmodule
